mul_div_sequencer: RTL and testbench

- Hardwired control sequencer for the single-bus datapath.
- Generates the select and enable strobes that fetch one instruction and execute the mul or div opcode in a fixed T0–T6 sequence; products and quotients land in LO/HI.
- The datapath only receives strobes; this block produces them, paced by a start request and a memory-ready handshake.
- Sits between the top-level controller and DataPath; its outputs connect one-to-one to the DataPath strobe inputs.

---
 rtl/mul_div_sequencer_if.sv | 50 +++++
 rtl/mul_div_sequencer.sv | 164 ++++++++++++++++
 tb/tb_mul_div_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_sequencer_if.sv
// rtl/mul_div_sequencer_if.sv - handshake and strobe bundle between controller, sequencer and DataPath.
// SEQ_SINGLE_STEP_EN adds the step input.
interface mul_div_sequencer_if;
    logic        start;
    logic        mem_ready;
    logic [31:0] ir_in;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step;
`endif
    logic        s_PC;
    logic        s_Zlow;
    logic        s_Zhigh;
    logic        s_MDR;
    logic [15:0] s_R;
    logic        e_MAR;
    logic        e_Z;
    logic        e_PC;
    logic        e_MDR;
    logic        e_IR;
    logic        e_Y;
    logic        e_HI;
    logic        e_LO;
    logic        e_alu;
    logic        w_IncPC;
    logic        w_read;
    logic [5:0]  opcode;
    logic        busy;
    logic        done;
    logic        illegal;

    modport slave (
        input  start, mem_ready, ir_in,
`ifdef SEQ_SINGLE_STEP_EN
        input  step,
`endif
        output s_PC, s_Zlow, s_Zhigh, s_MDR, s_R,
        output e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu,
        output w_IncPC, w_read, opcode, busy, done, illegal
    );

    modport master (
        output start, mem_ready, ir_in,
`ifdef SEQ_SINGLE_STEP_EN
        output step,
`endif
        input  s_PC, s_Zlow, s_Zhigh, s_MDR, s_R,
        input  e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu,
        input  w_IncPC, w_read, opcode, busy, done, illegal
    );
endinterface

// File: rtl/mul_div_sequencer.sv
// rtl/mul_div_sequencer.sv - hardwired T0-T6 fetch/execute strobe sequencer for mul/div.
// Optional single-step gating under SEQ_SINGLE_STEP_EN.
module mul_div_sequencer #(
    parameter int         ALU_CYCLES = 1,
    parameter logic [4:0] MUL_OP     = 5'b00101,
    parameter logic [4:0] DIV_OP     = 5'b00110
) (
    input logic                w_clock,
    input logic                w_clear_n,
    mul_div_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        DONE = 4'd8
    } state_t;

    localparam logic [4:0] CNT_LOAD = 5'(ALU_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [4:0] cnt;
    logic       first_q;
    logic       illegal_q;
    logic       ready;
    logic       legal;
    logic       step_ok;
    logic       fire;
    logic       unused_ir;

    assign legal     = (bus.ir_in[31:27] == MUL_OP) || (bus.ir_in[31:27] == DIV_OP);
    assign unused_ir = ^bus.ir_in[18:0];

`ifdef SEQ_SINGLE_STEP_EN
    logic held_q;
    assign step_ok = bus.step;
    // Load enables fire once; a state stretched only by step must not reload its register.
    assign fire    = !held_q;

    always_ff @(posedge w_clock or negedge w_clear_n) begin
        if (!w_clear_n) begin
            held_q <= 1'b0;
        end else begin
            held_q <= (state != IDLE) && ready && !bus.step;
        end
    end
`else
    assign step_ok = 1'b1;
    assign fire    = 1'b1;
`endif

    always_ff @(posedge w_clock or negedge w_clear_n) begin
        if (!w_clear_n) begin
            state     <= IDLE;
            cnt       <= '0;
            first_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_next;
            first_q   <= (state_next != state);
            illegal_q <= (state == T3) && (state_next == IDLE);
            if ((state == T3) && (state_next == T4)) begin
                cnt <= CNT_LOAD;
            end else if ((state == T4) && (cnt != '0)) begin
                cnt <= cnt - 5'd1;
            end
        end
    end

    // ready is the natural exit condition of each state, before step gating.
    always_comb begin
        ready      = 1'b1;
        state_next = state;
        case (state)
            T1:      ready = bus.mem_ready;
            T4:      ready = (cnt == '0);
            default: ready = 1'b1;
        endcase
        case (state)
            IDLE: if (bus.start)        state_next = T0;
            T0:   if (ready && step_ok) state_next = T1;
            T1:   if (ready && step_ok) state_next = T2;
            T2:   if (ready && step_ok) state_next = T3;
            T3:   if (ready && step_ok) state_next = legal ? T4 : IDLE;
            T4:   if (ready && step_ok) state_next = T5;
            T5:   if (ready && step_ok) state_next = T6;
            T6:   if (ready && step_ok) state_next = DONE;
            DONE: if (ready && step_ok) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.s_PC    = 1'b0;
        bus.s_Zlow  = 1'b0;
        bus.s_Zhigh = 1'b0;
        bus.s_MDR   = 1'b0;
        bus.s_R     = '0;
        bus.e_MAR   = 1'b0;
        bus.e_Z     = 1'b0;
        bus.e_PC    = 1'b0;
        bus.e_MDR   = 1'b0;
        bus.e_IR    = 1'b0;
        bus.e_Y     = 1'b0;
        bus.e_HI    = 1'b0;
        bus.e_LO    = 1'b0;
        bus.e_alu   = 1'b0;
        bus.w_IncPC = 1'b0;
        bus.w_read  = 1'b0;
        bus.opcode  = '0;
        bus.busy    = (state != IDLE);
        bus.done    = 1'b0;
        bus.illegal = 1'b0;
        case (state)
            IDLE: bus.illegal = illegal_q;
            T0: begin
                bus.s_PC    = 1'b1;
                bus.e_MAR   = fire;
                bus.w_IncPC = 1'b1;
                bus.e_Z     = fire;
            end
            T1: begin
                bus.s_Zlow  = 1'b1;
                bus.e_PC    = first_q;
                bus.w_read  = 1'b1;
                bus.e_MDR   = 1'b1;
            end
            T2: begin
                bus.s_MDR   = 1'b1;
                bus.e_IR    = fire;
            end
            T3: begin
                if (legal) begin
                    bus.s_R = 16'd1 << bus.ir_in[26:23];
                    bus.e_Y = fire;
                end
            end
            T4: begin
                bus.s_R     = 16'd1 << bus.ir_in[22:19];
                bus.e_alu   = 1'b1;
                bus.e_Z     = fire;
                bus.opcode  = {1'b0, bus.ir_in[31:27]};
            end
            T5: begin
                bus.s_Zlow  = 1'b1;
                bus.e_LO    = fire;
                bus.opcode  = {1'b0, bus.ir_in[31:27]};
            end
            T6: begin
                bus.s_Zhigh = 1'b1;
                bus.e_HI    = fire;
                bus.opcode  = {1'b0, bus.ir_in[31:27]};
            end
            DONE: bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb/tb_mul_div_sequencer.sv - scoreboard bench for mul_div_sequencer (ALU_CYCLES 1 and 4 instances).
module tb_mul_div_sequencer;
    typedef struct packed {
        logic        s_pc, s_zlow, s_zhigh, s_mdr;
        logic [15:0] s_r;
        logic        e_mar, e_z, e_pc, e_mdr, e_ir, e_y, e_hi, e_lo, e_alu, w_incpc, w_read;
        logic [5:0]  opcode;
        logic        busy, done, illegal;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_ready = 1'b1;
    logic [31:0] ir = '0;
    bit          sel = 1'b0;
    string       run_name = "reset";
    int          vectors = 0;
    int          miscompares = 0;
    obs_t        exp_q[$];
    string       tag_q[$];
    obs_t        obs_a, obs_b;

    always #5 clk = ~clk;

    mul_div_sequencer_if if_a();
    mul_div_sequencer_if if_b();

    assign if_a.start = start;  assign if_a.mem_ready = mem_ready;  assign if_a.ir_in = ir;
    assign if_b.start = start;  assign if_b.mem_ready = mem_ready;  assign if_b.ir_in = ir;
`ifdef SEQ_SINGLE_STEP_EN
    assign if_a.step = 1'b1;
    assign if_b.step = 1'b1;
`endif

    mul_div_sequencer #(.ALU_CYCLES(1)) dut_a (.w_clock(clk), .w_clear_n(rst_n), .bus(if_a));
    mul_div_sequencer #(.ALU_CYCLES(4)) dut_b (.w_clock(clk), .w_clear_n(rst_n), .bus(if_b));

    assign obs_a = {if_a.s_PC, if_a.s_Zlow, if_a.s_Zhigh, if_a.s_MDR, if_a.s_R, if_a.e_MAR, if_a.e_Z,
                    if_a.e_PC, if_a.e_MDR, if_a.e_IR, if_a.e_Y, if_a.e_HI, if_a.e_LO, if_a.e_alu,
                    if_a.w_IncPC, if_a.w_read, if_a.opcode, if_a.busy, if_a.done, if_a.illegal};
    assign obs_b = {if_b.s_PC, if_b.s_Zlow, if_b.s_Zhigh, if_b.s_MDR, if_b.s_R, if_b.e_MAR, if_b.e_Z,
                    if_b.e_PC, if_b.e_MDR, if_b.e_IR, if_b.e_Y, if_b.e_HI, if_b.e_LO, if_b.e_alu,
                    if_b.w_IncPC, if_b.w_read, if_b.opcode, if_b.busy, if_b.done, if_b.illegal};

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, sel ? obs_b : obs_a, e);
        end
    end

    task automatic push(input string st, input obs_t v);
        tag_q.push_back({run_name, ":", st});
        exp_q.push_back(v);
    endtask

    task automatic push_idle();
        push("IDLE", '0);
    endtask

    // Expected strobe trace of one instruction from T0 to DONE (or the illegal IDLE cycle).
    task automatic model_run(input logic [31:0] ins, input int mem_wait, input int alu_n);
        obs_t        v;
        logic        lgl;
        logic [5:0]  op;
        logic [15:0] ra, rb;
        logic [3:0]  fa, fb;
        lgl = (ins[31:27] == 5'b00101) || (ins[31:27] == 5'b00110);
        op  = {1'b0, ins[31:27]};
        fa  = ins[26:23];
        fb  = ins[22:19];
        ra  = 16'd1 << fa;
        rb  = 16'd1 << fb;
        v = '0; v.busy = 1; v.s_pc = 1; v.e_mar = 1; v.w_incpc = 1; v.e_z = 1;
        push("T0", v);
        for (int i = 0; i <= mem_wait; i++) begin
            v = '0; v.busy = 1; v.s_zlow = 1; v.w_read = 1; v.e_mdr = 1; v.e_pc = (i == 0);
            push($sformatf("T1[%0d]", i), v);
        end
        v = '0; v.busy = 1; v.s_mdr = 1; v.e_ir = 1;
        push("T2", v);
        v = '0; v.busy = 1;
        if (lgl) begin v.s_r = ra; v.e_y = 1; end
        push("T3", v);
        if (!lgl) begin
            v = '0; v.illegal = 1;
            push("ILL", v);
            return;
        end
        for (int i = 0; i < alu_n; i++) begin
            v = '0; v.busy = 1; v.s_r = rb; v.e_alu = 1; v.e_z = 1; v.opcode = op;
            push($sformatf("T4[%0d]", i), v);
        end
        v = '0; v.busy = 1; v.s_zlow = 1; v.e_lo = 1; v.opcode = op;
        push("T5", v);
        v = '0; v.busy = 1; v.s_zhigh = 1; v.e_hi = 1; v.opcode = op;
        push("T6", v);
        v = '0; v.busy = 1; v.done = 1;
        push("DONE", v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            check({run_name, ":drain_timeout"}, 40'(exp_q.size()), 40'd0);
            exp_q.delete();
            tag_q.delete();
        end
        repeat (8) tick();
    endtask

    task automatic simple_run(input string name, input bit s, input logic [31:0] ins, input int alu_n);
        run_name = name; sel = s; ir = ins; mem_ready = 1'b1;
        tick();
        start = 1'b1;
        push_idle(); model_run(ins, 0, alu_n); push_idle();
        tick();
        start = 1'b0;
        drain();
    endtask

    initial begin
        bit found;
        #3;
        check("reset_a", obs_a, 40'd0);
        check("reset_b", obs_b, 40'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        simple_run("mul", 1'b0, 32'h28918000, 1);

        run_name = "memwait"; sel = 1'b0; ir = 32'h28918000; mem_ready = 1'b0;
        tick();
        start = 1'b1;
        push_idle(); model_run(ir, 3, 1); push_idle();
        tick();
        start = 1'b0;
        repeat (4) tick();
        mem_ready = 1'b1;
        drain();

        simple_run("div4", 1'b1, 32'h30918000, 4);
        simple_run("illegal", 1'b0, 32'h18918000, 1);
        simple_run("r0r15", 1'b0, {5'b00101, 4'h0, 4'hF, 19'h0}, 1);
        simple_run("r15r0", 1'b1, {5'b00110, 4'hF, 4'h0, 19'h7FFFF}, 4);

        run_name = "restart_t2"; sel = 1'b0; ir = 32'h28918000;
        tick();
        start = 1'b1;
        push_idle(); model_run(ir, 0, 1); push_idle(); push_idle(); push_idle();
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        drain();

        run_name = "held"; sel = 1'b0;
        tick();
        start = 1'b1;
        push_idle(); model_run(ir, 0, 1); push_idle(); model_run(ir, 0, 1); push_idle();
        repeat (10) tick();
        start = 1'b0;
        drain();

        run_name = "rst_t4"; sel = 1'b1; ir = 32'h30918000;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (if_b.e_alu) found = 1'b1;
            else tick();
        end
        check("rst_t4:reach_t4", {39'd0, found}, 40'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_t4:async_b", obs_b, 40'd0);
        check("rst_t4:async_a", obs_a, 40'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_t4:post_idle", obs_b, 40'd0);
        simple_run("after_rst", 1'b1, 32'h30918000, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
